clap_detector: RTL

Input-side sound event receiver for the pet's sound channel. It conditions the raw digital output of the microphone module (KY-038-style comparator pin) and turns it into clean one-cycle event pulses. The actuator paths (buzzer and similar) are driven by single-cycle triggers; this block is the matching source of such triggers from the physical sound sensor. It synchronizes and filters the pin, detects claps, and classifies them as single or double claps for the pet state machine.

---
 rtl/clap_detector.sv | 137 +++++++++++++
 1 files changed

// File: rtl/clap_detector.sv
// clap_detector: synchronizes and debounces the microphone comparator pin, then
// classifies rising sound edges into one-cycle single_clap / double_clap pulses.
module clap_detector #(
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned FILTER_CYCLES  = 50_000,
    parameter int unsigned LOCKOUT_CYCLES = 5_000_000,
    parameter int unsigned WINDOW_CYCLES  = 25_000_000,
    parameter int unsigned ACTIVE_LOW     = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic sound_in,
    input  logic enable,
    output logic sound_level,
    output logic single_clap,
    output logic double_clap,
    output logic busy
);

    if (CLK_FREQ == 0 || FILTER_CYCLES == 0 || LOCKOUT_CYCLES == 0 || WINDOW_CYCLES == 0) begin : g_bad_params
        $error("clap_detector: clock and cycle parameters must all be at least 1");
    end

    localparam logic        INACTIVE_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [31:0] FILT_LAST    = 32'(FILTER_CYCLES - 1);
    localparam logic [31:0] LOCK_LAST    = 32'(LOCKOUT_CYCLES - 1);
    localparam logic [31:0] WIN_LAST     = 32'(WINDOW_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCK1 = 2'd1;
    localparam logic [1:0] WAIT2 = 2'd2;
    localparam logic [1:0] LOCK2 = 2'd3;

    logic        sync_meta;
    logic        sync_pin;
    logic        sound_now;
    logic [31:0] flt_cnt;
    logic        sound_level_d;
    logic        clap;
    logic [1:0]  state;
    logic [31:0] tcnt;

    // Synchronizer flops come out of reset at the idle pin level so no false edge is seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= INACTIVE_PIN;
            sync_pin  <= INACTIVE_PIN;
        end else begin
            sync_meta <= sound_in;
            sync_pin  <= sync_meta;
        end
    end

    assign sound_now = (ACTIVE_LOW != 0) ? ~sync_pin : sync_pin;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flt_cnt       <= '0;
            sound_level   <= 1'b0;
            sound_level_d <= 1'b0;
        end else begin
            sound_level_d <= sound_level;
            if (sound_now == sound_level) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FILT_LAST) begin
                sound_level <= sound_now;
                flt_cnt     <= '0;
            end else begin
                flt_cnt <= flt_cnt + 32'd1;
            end
        end
    end

    assign clap = sound_level & ~sound_level_d;

    // A clap arriving on the last window cycle wins over window expiry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            tcnt        <= '0;
            single_clap <= 1'b0;
            double_clap <= 1'b0;
        end else begin
            single_clap <= 1'b0;
            double_clap <= 1'b0;
            if (!enable) begin
                state <= IDLE;
                tcnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        tcnt <= '0;
                        if (clap) begin
                            state <= LOCK1;
                        end
                    end
                    LOCK1: begin
                        if (tcnt == LOCK_LAST) begin
                            state <= WAIT2;
                            tcnt  <= '0;
                        end else begin
                            tcnt <= tcnt + 32'd1;
                        end
                    end
                    WAIT2: begin
                        if (clap) begin
                            double_clap <= 1'b1;
                            state       <= LOCK2;
                            tcnt        <= '0;
                        end else if (tcnt == WIN_LAST) begin
                            single_clap <= 1'b1;
                            state       <= IDLE;
                            tcnt        <= '0;
                        end else begin
                            tcnt <= tcnt + 32'd1;
                        end
                    end
                    LOCK2: begin
                        if (tcnt == LOCK_LAST) begin
                            state <= IDLE;
                            tcnt  <= '0;
                        end else begin
                            tcnt <= tcnt + 32'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tcnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
